// File: rtl/l_load_sequencer.sv
// l_load_sequencer: front-end controller for the load buffer.
// Accepts one tagged command stream (CLAUSE/PTR/UC/EOF) over valid/ready and
// emits registered, mutually exclusive load pulses one cycle after acceptance.
// Engines are filled in order; a clause beyond the per-engine quota carries an
// engine-change pulse with it. All clause/ptr loads must come before any uc,
// and misuse sets a sticky error.
//
// Ports:
//   clock, reset        clock (rising edge) / async active-low reset
//   start_in            IDLE/DONE -> LOAD; clears engine index, clause count, error
//   hold_in             downstream stall; forces cmd_ready_out low
//   cmd_valid_in        command present
//   cmd_ready_out       combinational ready; accept = valid & ready
//   cmd_type_in         0=CLAUSE 1=PTR 2=UC 3=EOF
//   cmd_clause_in/ptr_in/uc_in   command payloads
//   clause_out/ptr_out/uc_out    registered payloads to the buffer
//   load_clause/ptr/change/uc_out registered single-cycle load pulses
//   engine_idx_out      engine currently being filled
//   done_out            high in DONE
//   err_out             sticky protocol error
//
// Optional feature macro LSEQ_STATS_EN adds stat_clauses_out / stat_drops_out
// saturating counters (cleared by reset and start_in).
module l_load_sequencer #(
  parameter int unsigned NUM_ENGINE     = 4,
  parameter int unsigned CLA_PER_ENGINE = 8,
  parameter int unsigned CLA_W          = 32,
  parameter int unsigned PTR_W          = 16,
  parameter int unsigned LIT_W          = 16,
  localparam int unsigned ENG_W = (NUM_ENGINE > 1) ? $clog2(NUM_ENGINE) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_in,
  input  logic             hold_in,
  input  logic             cmd_valid_in,
  output logic             cmd_ready_out,
  input  logic [1:0]       cmd_type_in,
  input  logic [CLA_W-1:0] cmd_clause_in,
  input  logic [PTR_W-1:0] cmd_ptr_in,
  input  logic [LIT_W-1:0] cmd_uc_in,
  output logic [CLA_W-1:0] clause_out,
  output logic [PTR_W-1:0] ptr_out,
  output logic [LIT_W-1:0] uc_out,
  output logic             load_clause_out,
  output logic             load_ptr_out,
  output logic             load_change_out,
  output logic             load_uc_out,
  output logic [ENG_W-1:0] engine_idx_out,
`ifdef LSEQ_STATS_EN
  output logic [15:0]      stat_clauses_out,
  output logic [7:0]       stat_drops_out,
`endif
  output logic             done_out,
  output logic             err_out
);

  localparam int unsigned CNT_W = $clog2(CLA_PER_ENGINE + 1);
  localparam logic [1:0] CMD_CLAUSE = 2'd0;
  localparam logic [1:0] CMD_PTR    = 2'd1;
  localparam logic [1:0] CMD_UC     = 2'd2;
  localparam logic [1:0] CMD_EOF    = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_UC, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [ENG_W-1:0] eng_q, eng_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [CLA_W-1:0] clause_q, clause_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [LIT_W-1:0] uc_q, uc_d;
  logic             ld_clause_q, ld_clause_d;
  logic             ld_ptr_q, ld_ptr_d;
  logic             ld_change_q, ld_change_d;
  logic             ld_uc_q, ld_uc_d;
  logic             drop;
  logic             accept;
  logic             start_go;

  assign cmd_ready_out = ((state_q == S_LOAD) || (state_q == S_UC)) && !hold_in;
  assign accept        = cmd_valid_in && cmd_ready_out;
  assign start_go      = start_in && ((state_q == S_IDLE) || (state_q == S_DONE));

  // State register and registered outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      eng_q       <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      clause_q    <= '0;
      ptr_q       <= '0;
      uc_q        <= '0;
      ld_clause_q <= 1'b0;
      ld_ptr_q    <= 1'b0;
      ld_change_q <= 1'b0;
      ld_uc_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      eng_q       <= eng_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      clause_q    <= clause_d;
      ptr_q       <= ptr_d;
      uc_q        <= uc_d;
      ld_clause_q <= ld_clause_d;
      ld_ptr_q    <= ld_ptr_d;
      ld_change_q <= ld_change_d;
      ld_uc_q     <= ld_uc_d;
    end
  end

  // Next-state and command decode
  always_comb begin
    state_d     = state_q;
    eng_d       = eng_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    clause_d    = clause_q;
    ptr_d       = ptr_q;
    uc_d        = uc_q;
    ld_clause_d = 1'b0;
    ld_ptr_d    = 1'b0;
    ld_change_d = 1'b0;
    ld_uc_d     = 1'b0;
    drop        = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start_go) begin
          state_d = S_LOAD;
          eng_d   = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      S_LOAD: begin
        if (accept) begin
          unique case (cmd_type_in)
            CMD_CLAUSE: begin
              if (cnt_q < CNT_W'(CLA_PER_ENGINE)) begin
                ld_clause_d = 1'b1;
                clause_d    = cmd_clause_in;
                cnt_d       = cnt_q + CNT_W'(1);
              end else if (eng_q < ENG_W'(NUM_ENGINE - 1)) begin
                // Quota reached: the clause opens the next engine
                ld_clause_d = 1'b1;
                ld_change_d = 1'b1;
                clause_d    = cmd_clause_in;
                eng_d       = eng_q + ENG_W'(1);
                cnt_d       = CNT_W'(1);
              end else begin
                drop = 1'b1;
              end
            end
            CMD_PTR: begin
              ld_ptr_d = 1'b1;
              ptr_d    = cmd_ptr_in;
            end
            CMD_UC:  drop    = 1'b1;
            CMD_EOF: state_d = S_UC;
            default: drop    = 1'b1;
          endcase
        end
      end
      S_UC: begin
        if (accept) begin
          unique case (cmd_type_in)
            CMD_UC: begin
              ld_uc_d = 1'b1;
              uc_d    = cmd_uc_in;
            end
            CMD_EOF: state_d = S_DONE;
            default: drop    = 1'b1;
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (drop) err_d = 1'b1;
  end

`ifdef LSEQ_STATS_EN
  logic [15:0] stat_cla_q;
  logic [7:0]  stat_drop_q;

  // Saturating counters, updated on the same edge as the issuing pulse
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stat_cla_q  <= '0;
      stat_drop_q <= '0;
    end else if (start_go) begin
      stat_cla_q  <= '0;
      stat_drop_q <= '0;
    end else begin
      if (ld_clause_d && (stat_cla_q != 16'hFFFF)) stat_cla_q <= stat_cla_q + 16'd1;
      if (drop && (stat_drop_q != 8'hFF))          stat_drop_q <= stat_drop_q + 8'd1;
    end
  end

  assign stat_clauses_out = stat_cla_q;
  assign stat_drops_out   = stat_drop_q;
`endif

  assign clause_out      = clause_q;
  assign ptr_out         = ptr_q;
  assign uc_out          = uc_q;
  assign load_clause_out = ld_clause_q;
  assign load_ptr_out    = ld_ptr_q;
  assign load_change_out = ld_change_q;
  assign load_uc_out     = ld_uc_q;
  assign engine_idx_out  = eng_q;
  assign done_out        = (state_q == S_DONE);
  assign err_out         = err_q;

endmodule

// File: tb/tb_l_load_sequencer.sv
// Testbench for l_load_sequencer: directed command vectors; expected load
// pulses are queued at issue time and a negedge monitor pops and compares them.
module tb_l_load_sequencer;

  localparam logic [1:0] CMD_CLAUSE = 2'd0;
  localparam logic [1:0] CMD_PTR    = 2'd1;
  localparam logic [1:0] CMD_UC     = 2'd2;
  localparam logic [1:0] CMD_EOF    = 2'd3;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start_in = 1'b0;
  logic        hold_in = 1'b0;
  logic        cmd_valid_in = 1'b0;
  logic        cmd_ready_out;
  logic [1:0]  cmd_type_in = 2'd0;
  logic [31:0] cmd_clause_in = '0;
  logic [15:0] cmd_ptr_in = '0;
  logic [15:0] cmd_uc_in = '0;
  logic [31:0] clause_out;
  logic [15:0] ptr_out;
  logic [15:0] uc_out;
  logic        load_clause_out, load_ptr_out, load_change_out, load_uc_out;
  logic [1:0]  engine_idx_out;
  logic        done_out, err_out;
`ifdef LSEQ_STATS_EN
  logic [15:0] stat_clauses_out;
  logic [7:0]  stat_drops_out;
`endif

  // pulses = {clause, ptr, change, uc}
  typedef struct packed {
    logic [3:0]  pulses;
    logic [31:0] data;
    logic [1:0]  eng;
  } exp_t;

  exp_t sb[$];
  int   vecs = 0;
  int   miscompares = 0;

  l_load_sequencer dut (
    .clock           (clock),
    .reset           (reset),
    .start_in        (start_in),
    .hold_in         (hold_in),
    .cmd_valid_in    (cmd_valid_in),
    .cmd_ready_out   (cmd_ready_out),
    .cmd_type_in     (cmd_type_in),
    .cmd_clause_in   (cmd_clause_in),
    .cmd_ptr_in      (cmd_ptr_in),
    .cmd_uc_in       (cmd_uc_in),
    .clause_out      (clause_out),
    .ptr_out         (ptr_out),
    .uc_out          (uc_out),
    .load_clause_out (load_clause_out),
    .load_ptr_out    (load_ptr_out),
    .load_change_out (load_change_out),
    .load_uc_out     (load_uc_out),
    .engine_idx_out  (engine_idx_out),
`ifdef LSEQ_STATS_EN
    .stat_clauses_out(stat_clauses_out),
    .stat_drops_out  (stat_drops_out),
`endif
    .done_out        (done_out),
    .err_out         (err_out)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [3:0] pl, input logic [31:0] d, input int eng);
    exp_t e;
    e.pulses = pl;
    e.data   = d;
    e.eng    = 2'(eng);
    return e;
  endfunction

  // Drive one command from a negedge; returns at the negedge after acceptance
  task automatic send(input logic [1:0] t, input logic [31:0] p, input bit has_exp, input exp_t e);
    int n = 0;
    cmd_type_in   = t;
    cmd_clause_in = p;
    cmd_ptr_in    = p[15:0];
    cmd_uc_in     = p[15:0];
    cmd_valid_in  = 1'b1;
    #1;
    while (!cmd_ready_out && n < 50) begin
      @(negedge clock);
      #1;
      n++;
    end
    if (!cmd_ready_out) begin
      vecs++;
      miscompares++;
      $display("FAIL send_timeout: cmd_ready_out=%0b, expected 1", cmd_ready_out);
    end else begin
      if (has_exp) sb.push_back(e);
      @(posedge clock);
    end
    @(negedge clock);
    cmd_valid_in = 1'b0;
  endtask

  task automatic start();
    start_in = 1'b1;
    @(negedge clock);
    start_in = 1'b0;
  endtask

  // Scoreboard monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset && (load_clause_out || load_ptr_out || load_change_out || load_uc_out)) begin
        if (sb.size() == 0) begin
          vecs++;
          miscompares++;
          $display("FAIL unexpected_pulse: got {cla,ptr,chg,uc}=%b, expected none",
                   {load_clause_out, load_ptr_out, load_change_out, load_uc_out});
        end else begin
          e = sb.pop_front();
          chk("pulses", 32'({load_clause_out, load_ptr_out, load_change_out, load_uc_out}),
              32'(e.pulses));
          chk("engine_idx", 32'(engine_idx_out), 32'(e.eng));
          if (e.pulses[3]) chk("clause_out", clause_out, e.data);
          if (e.pulses[2]) chk("ptr_out", 32'(ptr_out), e.data);
          if (e.pulses[0]) chk("uc_out", 32'(uc_out), e.data);
        end
      end
    end
  end

  exp_t none;

  initial begin
    none = mk(4'b0000, 32'h0, 0);

    // Reset state
    repeat (2) @(negedge clock);
    chk("rst_ready", 32'(cmd_ready_out), 32'h0);
    chk("rst_pulses", 32'({load_clause_out, load_ptr_out, load_change_out, load_uc_out}), 32'h0);
    chk("rst_engine", 32'(engine_idx_out), 32'h0);
    chk("rst_done", 32'(done_out), 32'h0);
    chk("rst_err", 32'(err_out), 32'h0);
    chk("rst_clause", clause_out, 32'h0);
    reset = 1'b1;
    @(negedge clock);
    chk("idle_ready", 32'(cmd_ready_out), 32'h0);

    // Three clauses, then reset with a fourth pulse in flight
    start();
    for (int k = 1; k <= 3; k++)
      send(CMD_CLAUSE, 32'hA0 + 32'(k), 1'b1, mk(4'b1000, 32'hA0 + 32'(k), 0));
    cmd_type_in   = CMD_CLAUSE;
    cmd_clause_in = 32'hAA;
    cmd_valid_in  = 1'b1;
    @(posedge clock);
    #1;
    chk("inflight_pulse", 32'(load_clause_out), 32'h1);
    reset = 1'b0;
    #1;
    chk("midrst_clause_pulse", 32'(load_clause_out), 32'h0);
    chk("midrst_clause_out", clause_out, 32'h0);
    chk("midrst_ready", 32'(cmd_ready_out), 32'h0);
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("postrst_ready", 32'(cmd_ready_out), 32'h0);
    end
    cmd_valid_in = 1'b0;

    // PTR, UC misuse in LOAD, EOF, UC, hold, EOF -> DONE
    start();
    send(CMD_PTR, 32'h1234, 1'b1, mk(4'b0100, 32'h1234, 0));
    chk("err_after_ptr", 32'(err_out), 32'h0);
    send(CMD_UC, 32'h0055, 1'b0, none);
    chk("err_uc_in_load", 32'(err_out), 32'h1);
    send(CMD_EOF, 32'h0, 1'b0, none);
    send(CMD_UC, 32'hBEEF, 1'b1, mk(4'b0001, 32'hBEEF, 0));
    hold_in       = 1'b1;
    cmd_type_in   = CMD_UC;
    cmd_uc_in     = 16'h0C0D;
    cmd_valid_in  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("hold_ready", 32'(cmd_ready_out), 32'h0);
      @(negedge clock);
    end
    hold_in = 1'b0;
    #1;
    chk("unhold_ready", 32'(cmd_ready_out), 32'h1);
    sb.push_back(mk(4'b0001, 32'h0C0D, 0));
    @(posedge clock);
    @(negedge clock);
    cmd_valid_in = 1'b0;
    send(CMD_EOF, 32'h0, 1'b0, none);
    chk("done", 32'(done_out), 32'h1);
    chk("done_ready", 32'(cmd_ready_out), 32'h0);

    // Restart from DONE, fill all engines, then overflow
    start();
    chk("restart_done", 32'(done_out), 32'h0);
    chk("restart_err", 32'(err_out), 32'h0);
    chk("restart_engine", 32'(engine_idx_out), 32'h0);
    for (int k = 1; k <= 32; k++) begin
      send(CMD_CLAUSE, 32'hC000_0000 + 32'(k), 1'b1,
           mk({1'b1, 1'b0, (k > 1) && (((k - 1) % 8) == 0), 1'b0},
              32'hC000_0000 + 32'(k), (k - 1) / 8));
      if (k == 9) chk("engine_after_9", 32'(engine_idx_out), 32'h1);
    end
    chk("err_before_ovf", 32'(err_out), 32'h0);
    send(CMD_CLAUSE, 32'hDEAD, 1'b0, none);
    chk("err_ovf", 32'(err_out), 32'h1);
    chk("engine_ovf", 32'(engine_idx_out), 32'h3);
    chk("clause_held", clause_out, 32'hC000_0020);

    repeat (2) @(negedge clock);
    chk("sb_empty", 32'(sb.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
